// File: rtl/myriadrf_pkg.sv
// Shared encodings for the multi-channel MyriadRF RX interface.
// Mode selects and assembler state constants.
package myriadrf_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_RAMP   = 2'b01;
    localparam logic [1:0] MODE_SWAP   = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_WAIT_I = 2'd2;
    localparam logic [1:0] ST_WAIT_Q = 2'd3;

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock valid/ready FIFO with full/empty flags.
// Holding output data is zero whenever the FIFO is empty.
module stream_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push;
    logic          pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_valid = !empty;
    // A full FIFO still accepts a word when one leaves in the same cycle.
    assign s_ready = !full || m_ready;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_data;
    end

endmodule

// File: rtl/myriadrf_rx_if_mc.sv
// Multi-channel MyriadRF RX interface: I/Q pair assembly, channel tags,
// frame decimation, ramp test source and status counters.
module myriadrf_rx_if_mc
    import myriadrf_pkg::*;
#(
    parameter int DW      = 12,
    parameter int NCH     = 1,
    parameter int CW      = (NCH > 1 ? $clog2(NCH) : 1),
    parameter int FIFO_AW = 2,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_i,
    input  logic [1:0]      mode_i,
    input  logic [7:0]      decim_i,
    input  logic            clr_i,
    input  logic [DW-1:0]   rxd,
    input  logic            rxiqsel,
    output logic [2*DW-1:0] m_data_o,
    output logic [CW-1:0]   m_chan_o,
    output logic            m_last_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [CNTW-1:0] ovf_cnt_o,
    output logic [CNTW-1:0] align_err_cnt_o,
    output logic            active_o
);

    localparam int FW = 2*DW + CW + 1;
    localparam logic [CW-1:0]   CH_LAST = CW'(NCH - 1);
    localparam logic [CW-1:0]   CH_ONE  = 1;
    localparam logic [DW-1:0]   DW_ONE  = 1;
    localparam logic [CNTW-1:0] CNT_ONE = 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [DW-1:0]   rxd_q, i_lat, ramp;
    logic            iq_q, phase;
    logic [1:0]      state, state_n;
    logic [CW-1:0]   chan;
    logic [7:0]      frm_cnt, decim_lat;
    logic            ramp_mode, i_load, align_hit, pair_done;
    logic            ramp_done, done, push, drop, last;
    logic [2*DW-1:0] pair;
    logic [FW-1:0]   fifo_in, fifo_out;
    logic            fifo_ready, fifo_full, fifo_empty;
    logic            flags_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q <= '0;
            iq_q  <= 1'b0;
        end else begin
            rxd_q <= rxd;
            iq_q  <= rxiqsel;
        end
    end

    assign ramp_mode = (mode_i == MODE_RAMP);

    // The sample FSM is frozen while the ramp source is selected.
    always_comb begin
        state_n   = state;
        i_load    = 1'b0;
        align_hit = 1'b0;
        pair_done = 1'b0;
        if (!enable_i) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_SYNC;
                ST_SYNC: begin
                    if (!ramp_mode && iq_q) begin
                        i_load  = 1'b1;
                        state_n = ST_WAIT_Q;
                    end
                end
                ST_WAIT_I: begin
                    if (!ramp_mode) begin
                        if (iq_q) begin
                            i_load  = 1'b1;
                            state_n = ST_WAIT_Q;
                        end else begin
                            align_hit = 1'b1;
                        end
                    end
                end
                ST_WAIT_Q: begin
                    if (!ramp_mode) begin
                        if (iq_q) begin
                            i_load    = 1'b1;
                            align_hit = 1'b1;
                        end else begin
                            pair_done = 1'b1;
                            state_n   = ST_WAIT_I;
                        end
                    end
                end
            endcase
        end
    end

    assign ramp_done = enable_i && (state != ST_IDLE) && ramp_mode && phase;
    assign done      = pair_done || ramp_done;
    assign pair      = ramp_done              ? {~ramp, ramp}  :
                       (mode_i == MODE_SWAP)  ? {i_lat, rxd_q} :
                                                {rxd_q, i_lat};
    assign last      = (chan == CH_LAST);
    assign push      = done && (frm_cnt == 8'd0);
    assign drop      = push && !fifo_ready;
    assign fifo_in   = {last, chan, pair};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            i_lat <= '0;
        end else begin
            state <= state_n;
            if (i_load) i_lat <= rxd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan      <= '0;
            frm_cnt   <= '0;
            decim_lat <= '0;
            ramp      <= '0;
            phase     <= 1'b0;
        end else if (!enable_i || state == ST_IDLE) begin
            chan      <= '0;
            frm_cnt   <= '0;
            decim_lat <= decim_i;
            ramp      <= '0;
            phase     <= 1'b0;
        end else begin
            phase <= ramp_mode ? ~phase : 1'b0;
            if (ramp_done) ramp <= ramp + DW_ONE;
            if (done) begin
                chan <= last ? '0 : chan + CH_ONE;
                if (last) begin
                    if (frm_cnt >= decim_lat) begin
                        frm_cnt   <= '0;
                        decim_lat <= decim_i;
                    end else begin
                        frm_cnt <= frm_cnt + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_o       <= '0;
            align_err_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_cnt_o       <= '0;
            align_err_cnt_o <= '0;
        end else begin
            if (drop && ovf_cnt_o != CNT_MAX)
                ovf_cnt_o <= ovf_cnt_o + CNT_ONE;
            if (align_hit && align_err_cnt_o != CNT_MAX)
                align_err_cnt_o <= align_err_cnt_o + CNT_ONE;
        end
    end

    stream_sync_fifo #(
        .DW (FW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (fifo_in),
        .s_valid (push),
        .s_ready (fifo_ready),
        .m_data  (fifo_out),
        .m_valid (m_valid_o),
        .m_ready (m_ready_i),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign flags_unused = fifo_full ^ fifo_empty;
    assign {m_last_o, m_chan_o, m_data_o} = fifo_out;
    assign active_o = (state != ST_IDLE);

endmodule
